// File: rtl/vram_arb_pkg.sv
// rtl/vram_arb_pkg.sv - shared state encoding and constants for the VRAM arbiter
package vram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK,
    DONE
  } state_t;

  localparam logic [7:0] OOR_DATA = 8'hFF;

endpackage

// File: rtl/vram_arb_starve_ctr.sv
// rtl/vram_arb_starve_ctr.sv - saturating count of cycles the host has been blocked by video
module vram_arb_starve_ctr
  import vram_arb_pkg::*;
#(
  parameter int LIMIT = 64
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_at_limit
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_limit = (r_cnt == LIM);

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter: video fetch first, host fills gaps
// with a starvation guard that forces one host slot.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 13,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_m_cs,
  input  logic                  i_m_we,
  input  logic [15:0]           i_m_addr,
  input  logic [7:0]            i_m_dat,
  output logic [7:0]            o_m_dat,
  output logic                  o_m_ack,
  input  logic                  i_v_req,
  input  logic [ADDR_WIDTH-1:0] i_v_addr,
  output logic [7:0]            o_v_dat,
  output logic                  o_v_valid,
  output logic                  o_v_miss,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [7:0]            o_mem_dat,
  output logic                  o_mem_we,
  input  logic [7:0]            i_mem_dat
);

  state_t r_state, w_next;

  logic [15:0] r_addr;
  logic [7:0]  r_wdat;
  logic        r_we;
  logic [7:0]  r_m_dat;
  logic        r_v_valid;
  logic        r_v_miss;

  logic w_at_limit;
  logic w_issue;
  logic w_host_own;
  logic w_in_range;
  logic w_start;

  assign w_in_range = ((r_addr >> ADDR_WIDTH) == 16'd0);
  assign w_issue    = (r_state == ISSUE);
  assign w_host_own = w_issue && (!i_v_req || w_at_limit);
  assign w_start    = (r_state == IDLE) && i_m_cs;

  vram_arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (r_state == IDLE),
    .i_inc     (w_issue && !w_host_own),
    .o_at_limit(w_at_limit)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Out-of-range accesses skip the RAM pipeline, so reads do not need WAIT.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_m_cs) w_next = ISSUE;
      ISSUE:   if (w_host_own) w_next = (!r_we && w_in_range) ? WAIT : ACK;
      WAIT:    w_next = ACK;
      ACK:     w_next = DONE;
      DONE:    if (!i_m_cs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_addr    <= '0;
      r_wdat    <= '0;
      r_we      <= 1'b0;
      r_m_dat   <= '0;
      r_v_valid <= 1'b0;
      r_v_miss  <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr <= i_m_addr;
        r_wdat <= i_m_dat;
        r_we   <= i_m_we;
      end
      if (r_state == WAIT) begin
        r_m_dat <= i_mem_dat;
      end else if (w_host_own && !w_in_range && !r_we) begin
        r_m_dat <= OOR_DATA;
      end
      r_v_valid <= i_v_req && !w_host_own;
      r_v_miss  <= i_v_req && w_host_own;
    end
  end

  always_comb begin
    o_mem_addr = '0;
    o_mem_we   = 1'b0;
    o_mem_dat  = r_wdat;
    if (w_host_own) begin
      if (w_in_range) begin
        o_mem_addr = r_addr[ADDR_WIDTH-1:0];
        o_mem_we   = r_we;
      end
    end else if (i_v_req) begin
      o_mem_addr = i_v_addr;
    end
  end

  assign o_m_ack   = (r_state == ACK);
  assign o_m_dat   = r_m_dat;
  assign o_v_dat   = i_mem_dat;
  assign o_v_valid = r_v_valid;
  assign o_v_miss  = r_v_miss;

endmodule
